mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only, F stage) and data port (read/write, M stage). It serialises the two ports into one outstanding memory transaction at a time. It tolerates variable memory wait states. It drives per-port stall outputs consumed by the hazard unit. Data requests get priority, and a bounded-streak rule guarantees fetch forward progress.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_DSTREAK, 4, max consecutive data grants allowed while a fetch is pending (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
fetch_req  in  1  fetch port request; held high until fetch_ack
fetch_addr  in  AW  fetch address; stable while fetch_req high
fetch_ack  out  1  one-cycle pulse; fetch_rdata valid this cycle
fetch_rdata  out  DW  registered fetch read data
data_req  in  1  data port request; held high until data_ack
data_we  in  1  1 = write, 0 = read; stable while data_req high
data_addr  in  AW  data address; stable while data_req high
data_wdata  in  DW  write data; stable while data_req high
data_ack  out  1  one-cycle pulse; data_rdata valid this cycle (reads)
data_rdata  out  DW  registered data read data
mem_req  out  1  memory transaction request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ready  in  1  memory completes transaction this cycle; sampled only while mem_req=1
mem_rdata  in  DW  memory read data, valid with mem_ready
stall_f  out  1  fetch stalled
stall_m  out  1  data access stalled

Behaviour:
- States: IDLE, BUSY_F, BUSY_D, DONE_F, DONE_D.
- Reset (reset=0, async): state=IDLE, streak=0. mem_req/mem_we=0. mem_addr/mem_wdata/fetch_rdata/data_rdata=0. fetch_ack/data_ack=0.
- IDLE arbitration, evaluated each cycle:
  - Data only -> BUSY_D.
  - Fetch only -> BUSY_F.
  - Both requesting: BUSY_D if streak<MAX_DSTREAK, else BUSY_F.
  - Neither -> stay in IDLE.
- Registers latched on the grant edge:
  - mem_addr always.
  - mem_we = data_we for a data grant, 0 for a fetch grant.
  - mem_wdata = data_wdata for a data grant.
- Streak counter:
  - Data grant with fetch_req=1 -> streak+1, saturating at MAX_DSTREAK.
  - Data grant with fetch_req=0 -> streak=0.
  - Fetch grant -> streak=0.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata held constant.
  - When mem_ready=1 -> go to DONE_x and capture mem_rdata into x_rdata. Capture occurs for writes too; the value is don't-care.
  - When mem_ready=0 -> stay in BUSY_x, with no timeout.
- DONE_x:
  - x_ack=1 and mem_req=0, with mem_we forced to 0.
  - No arbitration in this state -> IDLE next cycle.
  - The requester drops or renews its req in the following cycle.
- Latency:
  - Zero-wait memory: grant at edge 0, mem_req high in cycle 1 with mem_ready=1, ack in cycle 2.
  - Minimum 3 cycles per transaction; each wait state adds 1.
- Exactly one of fetch_ack/data_ack is high in any cycle, or neither.
- x_rdata holds its value until the next completion on that port.
- stall_f = fetch_req & ~fetch_ack (combinational). stall_m = data_req & ~data_ack (same form).
- Request dropped while granted (e.g. pipeline flush): the transaction still completes and the ack is still pulsed. The hazard unit discards it. The arbiter never aborts mem_req mid-transaction.
- Reset asserted mid-BUSY:
  - mem_req drops immediately (async) and no ack is issued.
  - The memory model must treat this as an abandoned transaction.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, BUSY_F, BUSY_D, DONE_F, DONE_D}.
  - Constant MEM_ARB_STREAK_W = $clog2(MAX_DSTREAK+1), supplied via a function.
- One natural sub-module: arb_streak_ctr, the saturating streak counter with clear and increment inputs and a limit-reached output. Everything else stays flat.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0 and stall_* follow the reqs. Release -> IDLE.
- Lone fetch: fetch_addr=0x100, mem_ready=1, mem_rdata=0xE3A00005 -> mem_req=1/mem_we=0/mem_addr=0x100 in cycle 1, fetch_ack with fetch_rdata=0xE3A00005 in cycle 2, stall_f high in cycles 0-1.
- Simultaneous: fetch 0x104 plus data write 0x200/0xDEADBEEF -> mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF first, data_ack at cycle 2, then fetch granted at edge 3 and fetch_ack at cycle 5.
- Starvation bound: data_req continuously renewed and fetch_req held, MAX_DSTREAK=4 -> grant order D,D,D,D,F,D..., streak returns to 0 after F.
- Wait states: data read 0x300, mem_ready low for 3 cycles then high with 0x12345678 -> mem_addr/mem_req stable for 4 cycles, data_ack one cycle later, stall_m high throughout.
- Reset mid-BUSY_D: assert reset on cycle 2 of a waited access -> mem_req=0 the same cycle, no data_ack after release, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_F,
    BUSY_D,
    DONE_F,
    DONE_D
  } arb_state_t;

  localparam int MEM_ARB_MAX_DSTREAK_DEF = 4;

  // Counter width able to hold 0..max_dstreak inclusive.
  function automatic int mem_arb_streak_w(input int max_dstreak);
    return $clog2(max_dstreak + 1);
  endfunction

  localparam int MEM_ARB_STREAK_W = mem_arb_streak_w(MEM_ARB_MAX_DSTREAK_DEF);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; master = arbiter, slave = pipeline/memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [DW-1:0] fetch_rdata;

  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ack;
  logic [DW-1:0] data_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  logic          stall_f;
  logic          stall_m;

  modport master (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_ready, mem_rdata,
    output fetch_ack, fetch_rdata, data_ack, data_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport slave (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_ready, mem_rdata,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  localparam int W = mem_arb_streak_w(MAX_DSTREAK);
  localparam logic [W-1:0] LIMIT = W'(MAX_DSTREAK);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment and an async active-low reset in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data ports onto one single-ported memory, data first with a bounded streak.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = MEM_ARB_MAX_DSTREAK_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.master bus
);
  arb_state_t    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic          grant_f, grant_d;
  logic          streak_at_limit;

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = mem_we_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    grant_f       = 1'b0;
    grant_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins unless it has already starved a waiting fetch for MAX_DSTREAK grants.
        if (bus.data_req && (!bus.fetch_req || !streak_at_limit)) begin
          grant_d     = 1'b1;
          state_d     = BUSY_D;
          mem_addr_d  = bus.data_addr;
          mem_we_d    = bus.data_we;
          mem_wdata_d = bus.data_wdata;
        end else if (bus.fetch_req) begin
          grant_f    = 1'b1;
          state_d    = BUSY_F;
          mem_addr_d = bus.fetch_addr;
          mem_we_d   = 1'b0;
        end
      end
      BUSY_F: begin
        if (bus.mem_ready) begin
          state_d       = DONE_F;
          fetch_rdata_d = bus.mem_rdata;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d      = DONE_D;
          data_rdata_d = bus.mem_rdata;
        end
      end
      DONE_F, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  arb_streak_ctr #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_streak (
    .clk     (clk),
    .reset   (reset),
    .clr     (grant_f | (grant_d & ~bus.fetch_req)),
    .inc     (grant_d & bus.fetch_req),
    .at_limit(streak_at_limit)
  );

  // mem_req comes straight from the state so an async reset drops it in the same cycle.
  assign bus.mem_req     = (state_q == BUSY_F) || (state_q == BUSY_D);
  assign bus.mem_we      = mem_we_q & bus.mem_req;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.fetch_ack   = (state_q == DONE_F);
  assign bus.data_ack    = (state_q == DONE_D);
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.stall_f     = bus.fetch_req & ~bus.fetch_ack;
  assign bus.stall_m     = bus.data_req & ~bus.data_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single/dual requests, streak bound, wait states, mid-access reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .MAX_DSTREAK(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled after a settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;

    // Reset held with random inputs: outputs stay zero, stalls follow the requests.
    for (int i = 0; i < 3; i++) begin
      step();
      bus.fetch_req  = 1'($urandom);
      bus.data_req   = 1'($urandom);
      bus.data_we    = 1'($urandom);
      bus.fetch_addr = $urandom;
      bus.data_addr  = $urandom;
      bus.data_wdata = $urandom;
      bus.mem_ready  = 1'($urandom);
      bus.mem_rdata  = $urandom;
      settle();
      check("rst_mem_req",   32'(bus.mem_req),   32'd0);
      check("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check("rst_mem_addr",  bus.mem_addr,       32'd0);
      check("rst_mem_wdata", bus.mem_wdata,      32'd0);
      check("rst_f_rdata",   bus.fetch_rdata,    32'd0);
      check("rst_d_rdata",   bus.data_rdata,     32'd0);
      check("rst_f_ack",     32'(bus.fetch_ack), 32'd0);
      check("rst_d_ack",     32'(bus.data_ack),  32'd0);
      check("rst_stall_f",   32'(bus.stall_f),   32'(bus.fetch_req));
      check("rst_stall_m",   32'(bus.stall_m),   32'(bus.data_req));
    end

    // Release reset with no requests: arbiter idles.
    step();
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b0;
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    step();
    settle();
    check("idle_mem_req", 32'(bus.mem_req), 32'd0);

    // Lone fetch, zero-wait memory.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h100;
    bus.mem_ready  = 1'b1;
    bus.mem_rdata  = 32'hE3A00005;
    settle();
    check("lf_c0_stall_f", 32'(bus.stall_f), 32'd1);
    check("lf_c0_mem_req", 32'(bus.mem_req), 32'd0);
    step();
    check("lf_c1_mem_req",  32'(bus.mem_req),   32'd1);
    check("lf_c1_mem_we",   32'(bus.mem_we),    32'd0);
    check("lf_c1_mem_addr", bus.mem_addr,       32'h100);
    check("lf_c1_stall_f",  32'(bus.stall_f),   32'd1);
    check("lf_c1_f_ack",    32'(bus.fetch_ack), 32'd0);
    step();
    check("lf_c2_f_ack",    32'(bus.fetch_ack), 32'd1);
    check("lf_c2_f_rdata",  bus.fetch_rdata,    32'hE3A00005);
    check("lf_c2_stall_f",  32'(bus.stall_f),   32'd0);
    check("lf_c2_mem_req",  32'(bus.mem_req),   32'd0);
    step();
    bus.fetch_req = 1'b0;
    bus.mem_rdata = 32'h55555555;
    settle();
    check("lf_c3_f_ack",    32'(bus.fetch_ack), 32'd0);
    check("lf_c3_f_hold",   bus.fetch_rdata,    32'hE3A00005);

    // Simultaneous fetch and data write: data first, then fetch.
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h104;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_addr  = 32'h200;
    bus.data_wdata = 32'hDEADBEEF;
    bus.mem_rdata  = 32'hAAAA0000;
    step();
    check("sim_c1_mem_req",   32'(bus.mem_req), 32'd1);
    check("sim_c1_mem_we",    32'(bus.mem_we),  32'd1);
    check("sim_c1_mem_addr",  bus.mem_addr,     32'h200);
    check("sim_c1_mem_wdata", bus.mem_wdata,    32'hDEADBEEF);
    step();
    check("sim_c2_d_ack",   32'(bus.data_ack),  32'd1);
    check("sim_c2_f_ack",   32'(bus.fetch_ack), 32'd0);
    check("sim_c2_stall_m", 32'(bus.stall_m),   32'd0);
    check("sim_c2_stall_f", 32'(bus.stall_f),   32'd1);
    check("sim_c2_mem_we",  32'(bus.mem_we),    32'd0);
    step();
    bus.data_req  = 1'b0;
    bus.data_we   = 1'b0;
    bus.mem_rdata = 32'h0BADF00D;
    settle();
    check("sim_c3_mem_req", 32'(bus.mem_req), 32'd0);
    step();
    check("sim_c4_mem_req",  32'(bus.mem_req), 32'd1);
    check("sim_c4_mem_we",   32'(bus.mem_we),  32'd0);
    check("sim_c4_mem_addr", bus.mem_addr,     32'h104);
    step();
    check("sim_c5_f_ack",   32'(bus.fetch_ack), 32'd1);
    check("sim_c5_f_rdata", bus.fetch_rdata,    32'h0BADF00D);
    check("sim_c5_d_ack",   32'(bus.data_ack),  32'd0);
    step();
    bus.fetch_req = 1'b0;

    // Starvation bound: both held, expect D,D,D,D,F repeated twice.
    step();
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'h500;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'h400;
    bus.mem_ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic exp_f;
      exp_f = (i == 4) || (i == 9);
      step();
      check($sformatf("sb%0d_mem_addr", i), bus.mem_addr, exp_f ? 32'h500 : 32'h400);
      check($sformatf("sb%0d_mem_req", i),  32'(bus.mem_req), 32'd1);
      step();
      check($sformatf("sb%0d_f_ack", i), 32'(bus.fetch_ack), 32'(exp_f));
      check($sformatf("sb%0d_d_ack", i), 32'(bus.data_ack),  32'(!exp_f));
      step();
    end
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b0;

    // Data read with three wait states.
    step();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 32'h300;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFF0000;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
      end
      settle();
      check($sformatf("ws_c%0d_mem_req", i),  32'(bus.mem_req),  32'd1);
      check($sformatf("ws_c%0d_mem_addr", i), bus.mem_addr,      32'h300);
      check($sformatf("ws_c%0d_stall_m", i),  32'(bus.stall_m),  32'd1);
      check($sformatf("ws_c%0d_d_ack", i),    32'(bus.data_ack), 32'd0);
    end
    step();
    check("ws_c5_d_ack",   32'(bus.data_ack), 32'd1);
    check("ws_c5_d_rdata", bus.data_rdata,    32'h12345678);
    check("ws_c5_stall_m", 32'(bus.stall_m),  32'd0);
    step();
    bus.data_req  = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset asserted in the middle of a waited data access.
    step();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h340;
    step();
    step();
    check("rb_c2_mem_req_pre", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    settle();
    check("rb_c2_mem_req", 32'(bus.mem_req),  32'd0);
    check("rb_c2_d_ack",   32'(bus.data_ack), 32'd0);
    check("rb_c2_d_rdata", bus.data_rdata,    32'd0);
    bus.data_req = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rb_post%0d_d_ack", i),   32'(bus.data_ack), 32'd0);
      check($sformatf("rb_post%0d_mem_req", i), 32'(bus.mem_req),  32'd0);
    end

    // Normal service resumes after the abandoned access.
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_addr  = 32'h380;
    bus.data_wdata = 32'hCAFEF00D;
    bus.mem_ready  = 1'b1;
    step();
    check("rr_c1_mem_we",    32'(bus.mem_we), 32'd1);
    check("rr_c1_mem_addr",  bus.mem_addr,    32'h380);
    check("rr_c1_mem_wdata", bus.mem_wdata,   32'hCAFEF00D);
    step();
    check("rr_c2_d_ack", 32'(bus.data_ack), 32'd1);
    step();
    bus.data_req = 1'b0;
    settle();
    check("rr_c3_d_ack", 32'(bus.data_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
